mult_32x32: RTL and testbench
=============================

// Module: mult_32x32
//
// PURPOSE
//  Sequential unsigned 32x32 -> 64-bit multiplier built around one 16x16 multiplier.
//  A one-cycle start launches the multiply; four accumulate cycles follow; busy brackets them.
//  Standalone arithmetic block for datapaths that can tolerate a 4-cycle multiply.
//
// PARAMETERS
//  none -- widths fixed: operands 32b, product 64b, internal partial product 16x16.
//
// PORTS
//  clk      in   1   rising-edge clock, single clock domain
//  reset    in   1   synchronous, active-low reset (sampled on rising clk)
//  start    in   1   launch request; sampled each rising edge while idle
//  a        in   32  multiplicand (unsigned), captured when start is accepted
//  b        in   32  multiplier (unsigned), captured when start is accepted
//  busy     out  1   1 while a multiply is in progress
//  product  out  64  a*b; registered, valid when busy=0 after a completed op
//
// BEHAVIOUR
//  - Reset (reset=0 at a rising edge): state=IDLE, busy=0, product=64'd0,
//    operand regs=0. Reset overrides everything, including an op in progress; the op is aborted.
//  - FSM states: IDLE, S0, S1, S2, S3.
//    IDLE: busy=0. If start=1 at edge k: capture a,b, product<=0, go to S0.
//    S0: product += a[15:0]  * b[15:0]          ; go to S1
//    S1: product += (a[31:16]* b[15:0])  << 16  ; go to S2
//    S2: product += (a[15:0] * b[31:16]) << 16  ; go to S3
//    S3: product += (a[31:16]* b[31:16]) << 32  ; go to IDLE
//  - busy is a registered output, 1 exactly in S0..S3. Four cycles total:
//    busy rises after edge k; busy falls and product holds its final value after edge k+4.
//  - Operand muxing selects the 16-bit halves from the captured registers. Live a/b may change
//    freely once start has been accepted.
//  - Accumulator is 64 bits. No overflow is possible; every partial sum fits.
//  - start while busy=1 is ignored; no queueing.
//  - start=1 held for multiple cycles: re-accepted on the first edge the FSM is back in IDLE.
//  - product holds its last result indefinitely in IDLE. It clears to 0 only on reset or on the
//    next accepted start. Intermediate partial sums are visible while busy=1.
//
// CONFIGURATION
//  MULT32X32_DONE_EN defined:
//   - adds output port 'done' (1b). It is a registered single-cycle pulse in the cycle after
//     edge k+4, i.e. coincident with busy falling to 0 and the final product.
//   - done=0 on reset.
//   - If start is accepted in that same IDLE cycle, done still pulses.
//  MULT32X32_DONE_EN undefined: no 'done' port; all other behaviour identical.
//
// TESTING
//  1. Reset held low 4 cycles, start=0 -> busy=0, product=0 throughout.
//  2. a=2, b=3, start 1 cycle -> busy=1 for exactly 4 cycles, then product=64'd6.
//  3. a=123, b=456 -> product=64'd56088; the previous result is held until this start.
//  4. a=10000000, b=10000000 -> product=64'h0000_5AF3_107A_4000.
//     a=b=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001.
//  5. Second start pulse while busy, with different a/b -> ignored; product matches the first operands.
//  6. reset=0 asserted during S1 -> next cycle busy=0, product=0; a subsequent start computes correctly.

Source files
------------

// File: rtl/mult_32x32_if.sv
// Operand/result bundle for the sequential 32x32 multiplier.
// Optional MULT32X32_DONE_EN adds the single-cycle 'done' completion pulse.
interface mult_32x32_if;
    localparam int unsigned OP_W   = 32;
    localparam int unsigned PROD_W = 64;

    logic              start;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic              busy;
    logic [PROD_W-1:0] product;
`ifdef MULT32X32_DONE_EN
    logic              done;

    modport master (output start, a, b, input busy, product, done);
    modport slave  (input start, a, b, output busy, product, done);
`else
    modport master (output start, a, b, input busy, product);
    modport slave  (input start, a, b, output busy, product);
`endif
endinterface

// File: rtl/mult_32x32.sv
// Sequential unsigned 32x32 -> 64 multiplier using a single 16x16 multiplier.
// Four accumulate cycles (S0..S3) follow an accepted start; busy brackets them.
// Optional feature macro: MULT32X32_DONE_EN adds a registered 'done' pulse.
module mult_32x32 (
    input  logic         clk,
    input  logic         reset,
    mult_32x32_if.slave  bus
);
    localparam int unsigned OP_W   = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned PP_W   = 32;
    localparam int unsigned PROD_W = 64;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S0   = 3'd1,
        S1   = 3'd2,
        S2   = 3'd3,
        S3   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [OP_W-1:0]     a_q, b_q;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic                busy_q, busy_d;
    logic                capture;
    logic                done_d;
    logic [HALF_W-1:0]   op_a, op_b;
    logic [PP_W-1:0]     pp;

    // Half-word operand selection from the captured registers and the shared 16x16 multiply
    always_comb begin
        op_a = a_q[HALF_W-1:0];
        op_b = b_q[HALF_W-1:0];
        unique case (state_q)
            S1:      op_a = a_q[OP_W-1:HALF_W];
            S2:      op_b = b_q[OP_W-1:HALF_W];
            S3: begin
                op_a = a_q[OP_W-1:HALF_W];
                op_b = b_q[OP_W-1:HALF_W];
            end
            default: ;
        endcase
        pp = PP_W'(op_a) * PP_W'(op_b);
    end

    // Next-state, accumulator and registered-output next values
    always_comb begin
        state_d = state_q;
        prod_d  = prod_q;
        busy_d  = 1'b0;
        capture = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    capture = 1'b1;
                    prod_d  = '0;
                    busy_d  = 1'b1;
                    state_d = S0;
                end
            end
            S0: begin
                prod_d  = prod_q + PROD_W'(pp);
                busy_d  = 1'b1;
                state_d = S1;
            end
            S1: begin
                prod_d  = prod_q + (PROD_W'(pp) << 16);
                busy_d  = 1'b1;
                state_d = S2;
            end
            S2: begin
                prod_d  = prod_q + (PROD_W'(pp) << 16);
                busy_d  = 1'b1;
                state_d = S3;
            end
            S3: begin
                prod_d  = prod_q + (PROD_W'(pp) << 32);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture, accumulator and busy registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            busy_q <= 1'b0;
        end else begin
            if (capture) begin
                a_q <= bus.a;
                b_q <= bus.b;
            end
            prod_q <= prod_d;
            busy_q <= busy_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.product = prod_q;

`ifdef MULT32X32_DONE_EN
    logic done_q;

    // Completion pulse, coincident with busy falling
    always_ff @(posedge clk) begin
        if (!reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign bus.done = done_q;
`else
    logic unused_done;
    assign unused_done = done_d;
`endif
endmodule

// File: tb/tb_mult_32x32.sv
// Self-checking bench for mult_32x32: directed vector table, multi-cycle
// corner sequences and randomized operands against a plain-arithmetic model.
module tb_mult_32x32;
    logic clk;
    logic reset;

    mult_32x32_if bus ();

    mult_32x32 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_total;
    int          n_pass;
    logic [63:0] last_prod;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        return 64'(x) * 64'(y);
    endfunction

    // One full operation; starts at a negedge, ends at the negedge after edge k+4
    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic [63:0] exp,
                         input string name);
        check({name, "_held"}, bus.product, last_prod);
        bus.a = x; bus.b = y; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = $urandom; bus.b = $urandom;
        check({name, "_busy_k"}, 64'(bus.busy), 64'd1);
        check({name, "_clr"}, bus.product, 64'd0);
`ifdef MULT32X32_DONE_EN
        check({name, "_done_lo"}, 64'(bus.done), 64'd0);
`endif
        @(negedge clk);
        check({name, "_part0"}, bus.product, 64'(x[15:0]) * 64'(y[15:0]));
        for (int i = 0; i < 2; i++) begin
            check({name, "_busy_mid"}, 64'(bus.busy), 64'd1);
            @(negedge clk);
        end
        check({name, "_busy_k3"}, 64'(bus.busy), 64'd1);
        @(negedge clk);
        check({name, "_busy_end"}, 64'(bus.busy), 64'd0);
        check({name, "_prod"}, bus.product, exp);
`ifdef MULT32X32_DONE_EN
        check({name, "_done"}, 64'(bus.done), 64'd1);
`endif
        last_prod = exp;
    endtask

    vec_t vecs[8];

    initial begin
        logic [31:0] ra, rb;
        n_total = 0; n_pass = 0; last_prod = 64'd0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        reset = 1'b0;

        vecs[0] = '{32'd2,          32'd3,          64'd6};
        vecs[1] = '{32'd123,        32'd456,        64'd56088};
        vecs[2] = '{32'd10000000,   32'd10000000,   64'h0000_5AF3_107A_4000};
        vecs[3] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
        vecs[4] = '{32'd0,          32'hDEAD_BEEF,  64'd0};
        vecs[5] = '{32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF};
        vecs[6] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000};
        vecs[7] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};

        // Reset held low for four cycles with start idle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_busy", 64'(bus.busy), 64'd0);
            check("rst_prod", bus.product, 64'd0);
`ifdef MULT32X32_DONE_EN
            check("rst_done", 64'(bus.done), 64'd0);
`endif
        end
        reset = 1'b1;
        @(negedge clk);

        // Directed vector table, with idle gaps to observe the held result
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
            for (int g = 0; g < 2; g++) begin
                @(negedge clk);
                check("idle_busy", 64'(bus.busy), 64'd0);
                check("idle_hold", bus.product, last_prod);
`ifdef MULT32X32_DONE_EN
                check("done_once", 64'(bus.done), 64'd0);
`endif
            end
        end

        // Start pulse while busy with different operands is ignored
        bus.a = 32'd2000; bus.b = 32'd3000; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.a = 32'd7; bus.b = 32'd9; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("ign_busy", 64'(bus.busy), 64'd1);
        @(negedge clk);
        @(negedge clk);
        check("ign_end", 64'(bus.busy), 64'd0);
        check("ign_prod", bus.product, 64'd6000000);
        @(negedge clk);
        check("ign_noqueue", 64'(bus.busy), 64'd0);
        check("ign_hold", bus.product, 64'd6000000);
        last_prod = 64'd6000000;

        // Start held high: re-accepted on the first IDLE edge
        bus.a = 32'd11; bus.b = 32'd13; bus.start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_busy", 64'(bus.busy), 64'd1);
        end
        bus.a = 32'h0012_3456; bus.b = 32'h0ABC_DEF0;
        @(negedge clk);
        check("hold_gap", 64'(bus.busy), 64'd0);
        check("hold_prod1", bus.product, 64'd143);
`ifdef MULT32X32_DONE_EN
        check("hold_done", 64'(bus.done), 64'd1);
`endif
        @(negedge clk);
        bus.start = 1'b0;
        check("hold_reacc", 64'(bus.busy), 64'd1);
        check("hold_clr", bus.product, 64'd0);
        repeat (4) @(negedge clk);
        check("hold_end", 64'(bus.busy), 64'd0);
        check("hold_prod2", bus.product, ref_mul(32'h0012_3456, 32'h0ABC_DEF0));
        last_prod = ref_mul(32'h0012_3456, 32'h0ABC_DEF0);

        // Reset asserted while in S1 aborts the operation
        bus.a = 32'hCAFE_F00D; bus.b = 32'h1234_5678; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_prod", bus.product, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_idle", 64'(bus.busy), 64'd0);
        last_prod = 64'd0;
        do_op(32'd2, 32'd3, 64'd6, "after_abort");

        // Randomized operands against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            ra = $urandom; rb = $urandom;
            if (i % 6 == 1) ra = 32'hFFFF_FFFF;
            if (i % 6 == 3) rb = {16'h0000, rb[15:0]};
            do_op(ra, rb, ref_mul(ra, rb), "rand");
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("rand_hold", bus.product, last_prod);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
